// File: rtl/hppb_mig_scheduler_if.sv
// Copy-request handshake between the migration scheduler (master) and the two page-copy channels (slave).
interface hppb_mig_scheduler_if;
  logic        ch0_req_valid;
  logic [63:0] ch0_req_src;
  logic [63:0] ch0_req_dst;
  logic        ch0_req_ready;
  logic        ch0_done;
  logic        ch1_req_valid;
  logic [63:0] ch1_req_src;
  logic [63:0] ch1_req_dst;
  logic        ch1_req_ready;
  logic        ch1_done;

  modport master (
    output ch0_req_valid, ch0_req_src, ch0_req_dst,
    output ch1_req_valid, ch1_req_src, ch1_req_dst,
    input  ch0_req_ready, ch0_done, ch1_req_ready, ch1_done
  );

  modport slave (
    input  ch0_req_valid, ch0_req_src, ch0_req_dst,
    input  ch1_req_valid, ch1_req_src, ch1_req_dst,
    output ch0_req_ready, ch0_done, ch1_req_ready, ch1_done
  );
endinterface

// File: rtl/hppb_mig_scheduler.sv
// Sequences hot-page migration groups into two page-copy channels with a
// bounded number of outstanding copies per channel.
//
// state      | meaning
// S_IDLE     | waiting for new_addr_available
// S_DISPATCH | issuing latched pairs and collecting completions
// S_DONE     | group finished; grp_done follows one cycle later
module hppb_mig_scheduler #(
  parameter int  MIG_GRP_SIZE = 16,
  parameter int  MAX_OUT      = 2,
  localparam int NP           = MIG_GRP_SIZE / 2
) (
  input  logic        axi4_mm_clk,
  input  logic        axi4_mm_rst,
  input  logic        new_addr_available,
  input  logic [63:0] src_addr  [NP],
  input  logic [63:0] dst_addr  [NP],
  input  logic [63:0] src_addr1 [NP],
  input  logic [63:0] dst_addr1 [NP],
  hppb_mig_scheduler_if.master ch,
  output logic        sched_busy,
  output logic        grp_done,
  output logic [63:0] mig_done_cnt,
  output logic [31:0] grp_drop_cnt
);
  localparam int IW = (NP > 1) ? $clog2(NP) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DONE} state_t;
  state_t state_q, state_d;

  logic [NP-1:0] mask_q    [2];
  logic [NP-1:0] new_mask  [2];
  logic [63:0]   src_q     [2][NP];
  logic [63:0]   dst_q     [2][NP];
  logic [CW-1:0] out_cnt_q [2];
  logic [IW-1:0] sel       [2];
  logic          req_valid [2];
  logic [63:0]   req_src   [2];
  logic [63:0]   req_dst   [2];
  logic          ready_in  [2];
  logic          done_in   [2];
  logic          hs        [2];
  logic          done_acc  [2];

  function automatic logic [IW-1:0] lowest_set(input logic [NP-1:0] m);
    lowest_set = '0;
    for (int i = NP - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = IW'(i);
    end
  endfunction

  assign ready_in[0]      = ch.ch0_req_ready;
  assign ready_in[1]      = ch.ch1_req_ready;
  assign done_in[0]       = ch.ch0_done;
  assign done_in[1]       = ch.ch1_done;
  assign ch.ch0_req_valid = req_valid[0];
  assign ch.ch0_req_src   = req_src[0];
  assign ch.ch0_req_dst   = req_dst[0];
  assign ch.ch1_req_valid = req_valid[1];
  assign ch.ch1_req_src   = req_src[1];
  assign ch.ch1_req_dst   = req_dst[1];

  // An entry is migratable only when both of its page addresses are populated.
  always_comb begin
    new_mask[0] = '0;
    new_mask[1] = '0;
    for (int i = 0; i < NP; i++) begin
      new_mask[0][i] = (src_addr[i]  != '0) && (dst_addr[i]  != '0);
      new_mask[1][i] = (src_addr1[i] != '0) && (dst_addr1[i] != '0);
    end
  end

  always_ff @(posedge axi4_mm_clk) begin
    if (axi4_mm_rst) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (new_addr_available)
          state_d = (new_mask[0] == '0 && new_mask[1] == '0) ? S_DONE : S_DISPATCH;
      end
      S_DISPATCH: begin
        if (mask_q[0] == '0 && mask_q[1] == '0 && out_cnt_q[0] == '0 && out_cnt_q[1] == '0)
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sched_busy = (state_q != S_IDLE);
    for (int c = 0; c < 2; c++) begin
      sel[c]       = lowest_set(mask_q[c]);
      req_valid[c] = (state_q == S_DISPATCH) && (mask_q[c] != '0) && (out_cnt_q[c] < CW'(MAX_OUT));
      req_src[c]   = req_valid[c] ? src_q[c][sel[c]] : '0;
      req_dst[c]   = req_valid[c] ? dst_q[c][sel[c]] : '0;
      hs[c]        = req_valid[c] && ready_in[c];
      done_acc[c]  = (state_q == S_DISPATCH) && done_in[c] && (out_cnt_q[c] != '0);
    end
  end

  always_ff @(posedge axi4_mm_clk) begin
    if (axi4_mm_rst) begin
      for (int c = 0; c < 2; c++) begin
        mask_q[c]    <= '0;
        out_cnt_q[c] <= '0;
        for (int i = 0; i < NP; i++) begin
          src_q[c][i] <= '0;
          dst_q[c][i] <= '0;
        end
      end
    end else if (state_q == S_IDLE && new_addr_available) begin
      mask_q[0] <= new_mask[0];
      mask_q[1] <= new_mask[1];
      for (int i = 0; i < NP; i++) begin
        src_q[0][i] <= src_addr[i];
        dst_q[0][i] <= dst_addr[i];
        src_q[1][i] <= src_addr1[i];
        dst_q[1][i] <= dst_addr1[i];
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (hs[c]) mask_q[c] <= mask_q[c] & ~(NP'(1) << sel[c]);
        if (hs[c] && !done_acc[c])      out_cnt_q[c] <= out_cnt_q[c] + CW'(1);
        else if (!hs[c] && done_acc[c]) out_cnt_q[c] <= out_cnt_q[c] - CW'(1);
      end
    end
  end

  always_ff @(posedge axi4_mm_clk) begin
    if (axi4_mm_rst) begin
      mig_done_cnt <= '0;
      grp_drop_cnt <= '0;
      grp_done     <= 1'b0;
    end else begin
      mig_done_cnt <= mig_done_cnt + 64'(done_acc[0]) + 64'(done_acc[1]);
      grp_done     <= (state_q == S_DONE);
      if (new_addr_available && state_q != S_IDLE && grp_drop_cnt != '1)
        grp_drop_cnt <= grp_drop_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_hppb_mig_scheduler.sv
// Randomised bench for hppb_mig_scheduler against a transaction-level model of per-channel work queues.
module tb_hppb_mig_scheduler;
  localparam int NP   = 8;
  localparam int MAXO = 2;

  logic        axi4_mm_clk = 1'b0;
  logic        axi4_mm_rst = 1'b1;
  logic        new_addr_available = 1'b0;
  logic [63:0] src_addr  [NP];
  logic [63:0] dst_addr  [NP];
  logic [63:0] src_addr1 [NP];
  logic [63:0] dst_addr1 [NP];
  logic        sched_busy;
  logic        grp_done;
  logic [63:0] mig_done_cnt;
  logic [31:0] grp_drop_cnt;

  hppb_mig_scheduler_if bus ();

  hppb_mig_scheduler #(.MIG_GRP_SIZE(2 * NP), .MAX_OUT(MAXO)) dut (
    .axi4_mm_clk       (axi4_mm_clk),
    .axi4_mm_rst       (axi4_mm_rst),
    .new_addr_available(new_addr_available),
    .src_addr          (src_addr),
    .dst_addr          (dst_addr),
    .src_addr1         (src_addr1),
    .dst_addr1         (dst_addr1),
    .ch                (bus.master),
    .sched_busy        (sched_busy),
    .grp_done          (grp_done),
    .mig_done_cnt      (mig_done_cnt),
    .grp_drop_cnt      (grp_drop_cnt)
  );

  always #5 axi4_mm_clk = ~axi4_mm_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model: a group is a pair of ordered work queues; copies in flight are plain counts.
  bit           m_busy = 0, m_closing = 0, m_gpulse = 0;
  logic [127:0] pend [2][$];
  int           m_out [2] = '{0, 0};
  logic [63:0]  m_cnt  = '0;
  logic [31:0]  m_drop = '0;

  int due [2][$];
  int ready_pct = 100, dly_fixed = 3, bp1 = 0;
  bit spur = 0;
  int hs_total = 0, first_hs1 = -1, gd_cyc = -1, gstart = 0;
  int hs0_cyc [$];

  function automatic logic [63:0] nz();
    logic [63:0] r;
    r = {$urandom, $urandom};
    if (r == '0) r = 64'd1;
    return r;
  endfunction

  function automatic logic [63:0] rnd_addr();
    return ($urandom_range(3) == 0) ? 64'd0 : nz();
  endfunction

  task automatic scramble();
    for (int i = 0; i < NP; i++) begin
      src_addr[i]  = rnd_addr();
      dst_addr[i]  = rnd_addr();
      src_addr1[i] = rnd_addr();
      dst_addr1[i] = rnd_addr();
    end
  endtask

  task automatic build(input int pat);
    for (int i = 0; i < NP; i++) begin
      case (pat)
        0: begin src_addr[i] = nz(); dst_addr[i] = nz(); src_addr1[i] = nz(); dst_addr1[i] = nz(); end
        1: begin src_addr[i] = 0; dst_addr[i] = 0; src_addr1[i] = 0; dst_addr1[i] = 0; end
        2: begin src_addr[i] = 0; dst_addr[i] = nz(); src_addr1[i] = 0; dst_addr1[i] = nz(); end
        default: scramble();
      endcase
    end
    if (pat == 1) begin
      src_addr[1] = nz();  dst_addr[1] = nz();
      src_addr[5] = nz();  dst_addr[5] = nz();
      src_addr[3] = nz();
      src_addr1[0] = nz(); dst_addr1[0] = nz();
      dst_addr1[4] = nz();
    end
  endtask

  task automatic check_and_model();
    logic        v [2];
    logic        dv [2], rdy [2], dn [2];
    logic [63:0] ds [2], dd [2];
    bit          fin, gp_n;
    int          t;
    dv[0] = bus.ch0_req_valid; ds[0] = bus.ch0_req_src; dd[0] = bus.ch0_req_dst;
    dv[1] = bus.ch1_req_valid; ds[1] = bus.ch1_req_src; dd[1] = bus.ch1_req_dst;
    rdy[0] = bus.ch0_req_ready; dn[0] = bus.ch0_done;
    rdy[1] = bus.ch1_req_ready; dn[1] = bus.ch1_done;
    chk_eq("sched_busy", sched_busy, m_busy);
    chk_eq("grp_done", grp_done, m_gpulse);
    chk_eq("mig_done_cnt", mig_done_cnt, m_cnt);
    chk_eq("grp_drop_cnt", grp_drop_cnt, m_drop);
    if (grp_done === 1'b1) gd_cyc = cyc;
    for (int c = 0; c < 2; c++) begin
      v[c] = m_busy && !m_closing && pend[c].size() > 0 && m_out[c] < MAXO;
      chk_eq($sformatf("ch%0d_valid", c), dv[c], v[c]);
      chk_eq($sformatf("ch%0d_src", c), ds[c], v[c] ? pend[c][0][127:64] : 64'd0);
      chk_eq($sformatf("ch%0d_dst", c), dd[c], v[c] ? pend[c][0][63:0] : 64'd0);
    end
    gp_n = 0;
    if (axi4_mm_rst) begin
      m_busy = 0; m_closing = 0; m_cnt = '0; m_drop = '0;
      for (int c = 0; c < 2; c++) begin pend[c].delete(); m_out[c] = 0; end
    end else if (!m_busy) begin
      if (new_addr_available) begin
        for (int i = 0; i < NP; i++) begin
          if (src_addr[i] != 0 && dst_addr[i] != 0)   pend[0].push_back({src_addr[i], dst_addr[i]});
          if (src_addr1[i] != 0 && dst_addr1[i] != 0) pend[1].push_back({src_addr1[i], dst_addr1[i]});
        end
        m_busy = 1;
        m_closing = (pend[0].size() == 0 && pend[1].size() == 0);
      end
    end else if (m_closing) begin
      m_busy = 0; m_closing = 0; gp_n = 1;
      if (new_addr_available && m_drop != '1) m_drop++;
    end else begin
      if (new_addr_available && m_drop != '1) m_drop++;
      fin = pend[0].size() == 0 && pend[1].size() == 0 && m_out[0] == 0 && m_out[1] == 0;
      for (int c = 0; c < 2; c++) begin
        if (dn[c] && m_out[c] > 0) begin m_out[c]--; m_cnt++; end
        if (v[c] && rdy[c]) begin
          void'(pend[c].pop_front());
          m_out[c]++;
          hs_total++;
          if (c == 0) hs0_cyc.push_back(cyc);
          if (c == 1 && first_hs1 < 0) first_hs1 = cyc;
          t = cyc + ((dly_fixed > 0) ? dly_fixed : int'($urandom_range(4, 1)));
          if (due[c].size() > 0 && t <= due[c][$]) t = due[c][$] + 1;
          due[c].push_back(t);
        end
      end
      if (fin) m_closing = 1;
    end
    m_gpulse = gp_n;
  endtask

  task automatic drive_resp();
    logic d [2], r [2];
    for (int c = 0; c < 2; c++) begin
      d[c] = spur;
      if (due[c].size() > 0 && due[c][0] <= cyc) begin
        void'(due[c].pop_front());
        d[c] = 1'b1;
      end
      if (c == 1 && bp1 > 0) begin r[c] = 1'b0; bp1--; end
      else r[c] = ($urandom_range(99) < ready_pct);
    end
    bus.ch0_done = d[0]; bus.ch0_req_ready = r[0];
    bus.ch1_done = d[1]; bus.ch1_req_ready = r[1];
  endtask

  task automatic cycle();
    @(negedge axi4_mm_clk);
    check_and_model();
    @(posedge axi4_mm_clk);
    #1;
    cyc++;
    new_addr_available = 1'b0;
    axi4_mm_rst = 1'b0;
    scramble();
    drive_resp();
  endtask

  task automatic start_group(input int pat);
    build(pat);
    hs_total = 0; first_hs1 = -1; gd_cyc = -1;
    hs0_cyc.delete();
    gstart = cyc;
    new_addr_available = 1'b1;
    cycle();
  endtask

  task automatic finish_group(input int ov);
    int n = 0;
    while ((m_busy || m_gpulse) && n < 600) begin
      if (ov > 0 && m_busy && !m_closing && $urandom_range(99) < ov) new_addr_available = 1'b1;
      cycle();
      n++;
    end
    chk_eq("grp_finish", sched_busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] base;
    int n;
    bus.ch0_req_ready = 1'b1; bus.ch1_req_ready = 1'b1;
    bus.ch0_done = 1'b0; bus.ch1_done = 1'b0;
    scramble();
    cycle();
    cycle();

    // full group, fixed 3-cycle completion latency
    base = m_cnt;
    start_group(0); finish_group(0);
    chk_eq("full_cnt", mig_done_cnt, base + 64'd16);

    base = m_cnt;
    start_group(1); finish_group(0);
    chk_eq("sparse_cnt", mig_done_cnt, base + 64'd3);
    chk_eq("sparse_ch0_n", hs0_cyc.size(), 2);
    if (hs0_cyc.size() == 2) begin
      chk_eq("sparse_ch0_first", hs0_cyc[0] - gstart, 1);
      chk_eq("sparse_ch0_gap", hs0_cyc[1] - hs0_cyc[0], 1);
    end

    base = m_cnt;
    start_group(2); finish_group(0);
    chk_eq("empty_cnt", mig_done_cnt, base);
    chk_eq("empty_gdone_lat", gd_cyc - gstart, 2);

    base = m_cnt;
    bp1 = 10;
    start_group(0); finish_group(0);
    chk_eq("bp_first_hs1", first_hs1 - gstart, 11);
    chk_eq("bp_first_hs0", hs0_cyc[0] - gstart, 1);
    chk_eq("bp_cnt", mig_done_cnt, base + 64'd16);

    base = m_cnt;
    start_group(0);
    cycle(); cycle();
    new_addr_available = 1'b1;
    cycle();
    finish_group(0);
    chk_eq("overlap_drop", grp_drop_cnt, 32'd1);
    chk_eq("overlap_cnt", mig_done_cnt, base + 64'd16);

    base = m_cnt;
    spur = 1'b1;
    cycle(); cycle(); cycle();
    spur = 1'b0;
    cycle();
    chk_eq("spur_cnt", mig_done_cnt, base);

    // reset after three channel-0 handshakes while channel 1 is held off
    bp1 = 60;
    start_group(0);
    n = 0;
    while (hs_total < 3 && n < 100) begin cycle(); n++; end
    chk_eq("rst_hs_reached", hs_total, 3);
    axi4_mm_rst = 1'b1;
    bp1 = 0;
    cycle();
    chk_eq("rst_busy", sched_busy, 1'b0);
    chk_eq("rst_v0", bus.ch0_req_valid, 1'b0);
    chk_eq("rst_v1", bus.ch1_req_valid, 1'b0);
    chk_eq("rst_cnt", mig_done_cnt, 64'd0);
    n = 0;
    while ((due[0].size() > 0 || due[1].size() > 0) && n < 50) begin cycle(); n++; end
    cycle();
    chk_eq("rst_late_cnt", mig_done_cnt, 64'd0);
    start_group(0); finish_group(0);
    chk_eq("rst_next_cnt", mig_done_cnt, 64'd16);

    dly_fixed = 0;
    repeat (30) begin
      ready_pct = $urandom_range(100, 30);
      start_group(3);
      if ($urandom_range(5) == 0) begin
        repeat ($urandom_range(15)) cycle();
        axi4_mm_rst = 1'b1;
        cycle();
      end else begin
        finish_group(5);
      end
      if ($urandom_range(3) == 0) begin
        spur = 1'b1; cycle(); spur = 1'b0;
      end
      cycle();
    end
    repeat (10) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
